// File: rtl/gpio_irq.sv
// gpio_irq: parametrised GPIO slave with per-pin direction,
// atomic output ops and edge-capture interrupt.
module gpio_irq #(
    parameter int NUM_IO      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic [NUM_IO-1:0] io_pin_i,
    output logic [NUM_IO-1:0] io_out_o,
    output logic [NUM_IO-1:0] io_oe_o,
    output logic              irq_o
);

    localparam logic [5:0] OFF_DIR  = 6'd0;
    localparam logic [5:0] OFF_OUT  = 6'd1;
    localparam logic [5:0] OFF_IN   = 6'd2;
    localparam logic [5:0] OFF_RISE = 6'd3;
    localparam logic [5:0] OFF_FALL = 6'd4;
    localparam logic [5:0] OFF_STAT = 6'd5;
    localparam logic [5:0] OFF_SET  = 6'd6;
    localparam logic [5:0] OFF_CLR  = 6'd7;
    localparam logic [5:0] OFF_TGL  = 6'd8;

    logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_q;
    logic [NUM_IO-1:0] prev_q;
    logic [NUM_IO-1:0] dir_q, dir_d;
    logic [NUM_IO-1:0] out_q, out_d;
    logic [NUM_IO-1:0] rise_q, rise_d;
    logic [NUM_IO-1:0] fall_q, fall_d;
    logic [NUM_IO-1:0] status_q, status_d;

    logic [5:0]        off;
    logic [NUM_IO-1:0] wdata;
    logic [NUM_IO-1:0] sync;
    logic [NUM_IO-1:0] rise_ev;
    logic [NUM_IO-1:0] fall_ev;
    logic [NUM_IO-1:0] clr_mask;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign off   = addr_i[7:2];
    assign wdata = data_i[NUM_IO-1:0];
    assign sync  = sync_q[SYNC_STAGES-1];

    // Only the word offset and the low NUM_IO data bits matter.
    assign unused_ok = ^{addr_i[31:8], addr_i[1:0], data_i};

    assign rise_ev = sync & ~prev_q & rise_q;
    assign fall_ev = ~sync & prev_q & fall_q;

    // Input synchroniser chain plus one-cycle history for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
            sync_q[0] <= io_pin_i;
            prev_q    <= sync;
        end
    end

    // Register writes; STATUS set terms override a same-cycle W1C.
    always_comb begin
        dir_d    = dir_q;
        out_d    = out_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        clr_mask = '0;
        if (we_i) begin
            case (off)
                OFF_DIR:  dir_d    = wdata;
                OFF_OUT:  out_d    = wdata;
                OFF_RISE: rise_d   = wdata;
                OFF_FALL: fall_d   = wdata;
                OFF_STAT: clr_mask = wdata;
                OFF_SET:  out_d    = out_q | wdata;
                OFF_CLR:  out_d    = out_q & ~wdata;
                OFF_TGL:  out_d    = out_q ^ wdata;
                default:  ;
            endcase
        end
        status_d = (status_q & ~clr_mask) | rise_ev | fall_ev;
    end

    // Control and status register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q    <= '0;
            out_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
        end else begin
            dir_q    <= dir_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
        end
    end

    // Zero-wait-state read mux; unused upper bits read as zero.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_DIR:  rdata[NUM_IO-1:0] = dir_q;
            OFF_OUT:  rdata[NUM_IO-1:0] = out_q;
            OFF_IN:   rdata[NUM_IO-1:0] = sync;
            OFF_RISE: rdata[NUM_IO-1:0] = rise_q;
            OFF_FALL: rdata[NUM_IO-1:0] = fall_q;
            OFF_STAT: rdata[NUM_IO-1:0] = status_q;
            default:  rdata = '0;
        endcase
    end

    assign data_o   = rdata;
    assign io_out_o = out_q;
    assign io_oe_o  = dir_q;
    assign irq_o    = |(status_q & (rise_q | fall_q));

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised successor to the SoC's 16-pin GPIO slave: `NUM_IO` pins, per-pin direction, atomic set/clear/toggle of output data, and synchronised inputs with per-pin rising/falling edge capture into a sticky status register. It raises a single level interrupt.

- Sits on one RIB slave port: the interconnect decodes `addr_i[31:28]`, so this block sees only slave-local offsets.
- Tri-state pads are built outside the block from `io_out_o` and `io_oe_o`.
- `irq_o` feeds one bit of the core's `int_i` vector.

## Interface
Parameters:
- `NUM_IO`, default 16: pin count, legal range 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, legal range 2..3.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `we_i`  in  1: write strobe; 1 = write this cycle.
- `addr_i`  in  32: byte address.
  - Only `[7:2]` is decoded.
  - `[1:0]` and `[31:8]` are ignored.
- `data_i`  in  32: write data.
- `data_o`  out  32: read data, combinational from `addr_i` and register state.
- `io_pin_i`  in  NUM_IO: raw pad inputs, asynchronous to `clk`.
- `io_out_o`  out  NUM_IO: output data, equal to the OUT register.
- `io_oe_o`  out  NUM_IO: output enable, equal to the DIR register; 1 = drive.
- `irq_o`  out  1: OR-reduction of `STATUS & (RISE | FALL)`.

## Operation
Register map (word offsets). Bits at positions ≥ NUM_IO read 0 and ignore writes.
- 0x00 DIR (rw): per-pin output enable.
- 0x04 OUT (rw): output data.
- 0x08 IN (ro): synchroniser output; writes ignored.
- 0x0C RISE (rw): rising-edge capture enable.
- 0x10 FALL (rw): falling-edge capture enable.
- 0x14 STATUS (rw1c):
  - Writing 1 clears the bit; writing 0 has no effect.
  - A bit is set when an enabled edge occurs on its pin.
- 0x18 SET (wo): OUT ← OUT | data_i. Reads 0.
- 0x1C CLR (wo): OUT ← OUT & ~data_i. Reads 0.
- 0x20 TGL (wo): OUT ← OUT ^ data_i. Reads 0.
- Other offsets: read 0, writes ignored.

Input path:
- `io_pin_i` passes through a `SYNC_STAGES`-deep flop chain; the last stage is `sync`.
- `prev` is `sync` delayed by one cycle.
- Edge terms:
  - `rise = sync & ~prev & RISE`
  - `fall = ~sync & prev & FALL`
- STATUS update each cycle: STATUS ← (STATUS & ~clr_mask) | rise | fall.
  - `clr_mask = data_i` when `we_i` is high and the offset is 0x14; otherwise 0.
  - An edge in the same cycle as a W1C of the same bit leaves the bit set (set wins).
- Input capture is independent of DIR: a pin driven as output still reports its pad level and can capture edges.
- Changing RISE/FALL does not retroactively create events. Only transitions of `sync` while the enable is 1 are captured.
- STATUS bits stay set after their enable is cleared, but are masked from `irq_o`.

## Timing
- Reset (`rst` = 0, asynchronous): DIR, OUT, RISE, FALL, STATUS, all sync flops and `prev` go to 0. Resulting outputs:
  - `io_out_o` = 0
  - `io_oe_o` = 0
  - `irq_o` = 0
  - `data_o` = 0 for every offset except IN, which also reads 0 until the synchroniser fills.
- Reset asserted mid-operation clears pending STATUS immediately.
- Register writes take effect at the rising edge where `we_i` = 1; `io_out_o`/`io_oe_o` change one edge after the write cycle.
- Reads: zero wait state; `data_o` is valid in the same cycle as `addr_i`.
- Input latency, for a pin change before edge E1:
  - IN reflects the change after edge E(SYNC_STAGES).
  - STATUS bit and `irq_o` assert after edge E(SYNC_STAGES+1).
- Releasing reset with a pin held high produces a `sync` 0→1 transition. It is captured only if RISE is already 1, which is impossible straight out of reset.
- Pulses shorter than one clock period may be missed; no capture is guaranteed for them.
- Simultaneous events:
  - Rise and fall enabled on the same pin with a single transition set the bit once.
  - Several pins may set STATUS bits in the same cycle.

## Test plan
- Reset values: hold `rst` = 0, then release. Read all offsets → 0; `io_oe_o` = 0, `io_out_o` = 0, `irq_o` = 0.
- Output ops (`NUM_IO` = 16):
  - Write DIR = 0xFFFF, OUT = 0x00F0 → `io_out_o` = 0x00F0 one edge later.
  - SET 0x0001 → 0x00F1; CLR 0x0010 → 0x00E1; TGL 0xFFFF → 0xFF1E.
  - Write OUT = 0xFFFFFFFF → readback 0x0000FFFF.
- Rising-edge IRQ (`SYNC_STAGES` = 2):
  - RISE = 0x0004; drive pin 2 0→1 before edge E1 → STATUS = 0x0004 and `irq_o` = 1 after E3.
  - Write 0x0004 to STATUS → `irq_o` = 0 next edge.
- Falling edge and mask:
  - FALL = 0x0100; pin 8 1→0 → STATUS = 0x0100, `irq_o` = 1.
  - Clear FALL → `irq_o` = 0 while STATUS still reads 0x0100.
- Set-wins collision: W1C of bit 2 in the exact cycle its rise is detected → STATUS bit 2 remains 1, `irq_o` stays 1.
- Async reset mid-flight: assert `rst` with STATUS = 0x0104 and OUT = 0xAAAA → STATUS, OUT and `irq_o` go to 0 without waiting for a clock edge.
